// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: byte-level command sequencer that makes a single-mode
// SPI device behave as a read-only SPI flash. It supports READ (0x03),
// JEDEC ID (0x9F) and READ STATUS (0x05). Data bytes are prefetched from a
// memory backend into a one-byte holding register. When the optional macro
// SPI_FLASH_FAST_READ_EN is defined, FAST READ (0x0B) is also decoded. It
// inserts one dummy byte between the address and the first data byte.
module spi_flash_sequencer #(
    parameter int          ADDR_WIDTH = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS     = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  spi_timeout,
    input  logic                  spi_rx_cmd,
    input  logic                  spi_rx_strobe,
    input  logic [7:0]            spi_rx_data,
    output logic [7:0]            spi_tx_data,
    output logic                  spi_tx_strobe,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_valid,
    input  logic [7:0]            mem_rd_data,
    output logic                  busy,
    output logic                  underrun
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
`ifdef SPI_FLASH_FAST_READ_EN
        DUMMY,
`endif
        DATA,
        ID,
        STAT,
        IGNORE
    } state_t;

    state_t                state_q, state_d;
    logic                  csMeta_q, csSync_q;
    logic [7:0]            addrHi_q, addrHi_d;
    logic [7:0]            addrMid_q, addrMid_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [7:0]            hold_q, hold_d;
    logic                  holdOk_q, holdOk_d;
    logic                  loaded_q, loaded_d;
    logic                  pending_q, pending_d;
    logic [1:0]            idCnt_q, idCnt_d;
    logic [7:0]            txData_q, txData_d;
    logic                  txStrobe_q, txStrobe_d;
    logic                  rdReq_q, rdReq_d;
    logic                  underrun_q, underrun_d;
`ifdef SPI_FLASH_FAST_READ_EN
    logic                  fastRead_q, fastRead_d;
`endif

    logic                  abort;
    logic [23:0]           fullAddr;

    assign abort    = csSync_q | spi_timeout;
    assign fullAddr = {addrHi_q, addrMid_q, spi_rx_data};

    // Two-flop synchronizer for the raw chip select; resets to deselected.
    always_ff @(posedge clk) begin
        if (reset) begin
            csMeta_q <= 1'b1;
            csSync_q <= 1'b1;
        end else begin
            csMeta_q <= spi_cs;
            csSync_q <= csMeta_q;
        end
    end

    // State and datapath registers; every output is driven from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addrHi_q   <= 8'h00;
            addrMid_q  <= 8'h00;
            memAddr_q  <= '0;
            hold_q     <= 8'h00;
            holdOk_q   <= 1'b0;
            loaded_q   <= 1'b0;
            pending_q  <= 1'b0;
            idCnt_q    <= 2'd0;
            txData_q   <= 8'hFF;
            txStrobe_q <= 1'b0;
            rdReq_q    <= 1'b0;
            underrun_q <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fastRead_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addrHi_q   <= addrHi_d;
            addrMid_q  <= addrMid_d;
            memAddr_q  <= memAddr_d;
            hold_q     <= hold_d;
            holdOk_q   <= holdOk_d;
            loaded_q   <= loaded_d;
            pending_q  <= pending_d;
            idCnt_q    <= idCnt_d;
            txData_q   <= txData_d;
            txStrobe_q <= txStrobe_d;
            rdReq_q    <= rdReq_d;
            underrun_q <= underrun_d;
`ifdef SPI_FLASH_FAST_READ_EN
            fastRead_q <= fastRead_d;
`endif
        end
    end

    // Next-state logic. Priority is abort, then a new command byte, then the
    // per-state handling. Only a fetch that is still outstanding may fill the
    // holding register, so a response that lands after an abort is dropped.
    always_comb begin
        state_d    = state_q;
        addrHi_d   = addrHi_q;
        addrMid_d  = addrMid_q;
        memAddr_d  = memAddr_q;
        hold_d     = hold_q;
        holdOk_d   = holdOk_q;
        loaded_d   = loaded_q;
        pending_d  = pending_q;
        idCnt_d    = idCnt_q;
        txData_d   = txData_q;
        txStrobe_d = 1'b0;
        rdReq_d    = 1'b0;
        underrun_d = underrun_q;
`ifdef SPI_FLASH_FAST_READ_EN
        fastRead_d = fastRead_q;
`endif

        if (pending_q && mem_rd_valid) begin
            hold_d    = mem_rd_data;
            holdOk_d  = 1'b1;
            pending_d = 1'b0;
        end

        if (abort) begin
            state_d   = IDLE;
            txData_d  = 8'hFF;
            holdOk_d  = 1'b0;
            pending_d = 1'b0;
            loaded_d  = 1'b0;
        end else if (spi_rx_cmd) begin
            holdOk_d  = 1'b0;
            pending_d = 1'b0;
            loaded_d  = 1'b0;
            txData_d  = 8'hFF;
            case (spi_rx_data)
                8'h03: begin
                    state_d = ADDR2;
`ifdef SPI_FLASH_FAST_READ_EN
                    fastRead_d = 1'b0;
`endif
                end
`ifdef SPI_FLASH_FAST_READ_EN
                8'h0B: begin
                    state_d    = ADDR2;
                    fastRead_d = 1'b1;
                end
`endif
                8'h9F: begin
                    state_d    = ID;
                    txData_d   = JEDEC_ID[23:16];
                    txStrobe_d = 1'b1;
                    idCnt_d    = 2'd1;
                end
                8'h05: begin
                    state_d    = STAT;
                    txData_d   = STATUS;
                    txStrobe_d = 1'b1;
                end
                default: state_d = IGNORE;
            endcase
        end else begin
            case (state_q)
                ADDR2: begin
                    if (spi_rx_strobe) begin
                        addrHi_d = spi_rx_data;
                        state_d  = ADDR1;
                    end
                end
                ADDR1: begin
                    if (spi_rx_strobe) begin
                        addrMid_d = spi_rx_data;
                        state_d   = ADDR0;
                    end
                end
                ADDR0: begin
                    if (spi_rx_strobe) begin
                        memAddr_d = fullAddr[ADDR_WIDTH-1:0];
                        rdReq_d   = 1'b1;
                        pending_d = 1'b1;
                        loaded_d  = 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
                        if (fastRead_q) begin
                            state_d    = DUMMY;
                            txData_d   = 8'hFF;
                            txStrobe_d = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
`else
                        state_d = DATA;
`endif
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                    if (spi_rx_strobe) begin
                        state_d = DATA;
                    end
                end
`endif
                DATA: begin
                    if (holdOk_q && (!loaded_q || spi_rx_strobe)) begin
                        txData_d   = hold_q;
                        txStrobe_d = 1'b1;
                        memAddr_d  = memAddr_q + ADDR_WIDTH'(1);
                        rdReq_d    = 1'b1;
                        pending_d  = 1'b1;
                        holdOk_d   = 1'b0;
                        loaded_d   = 1'b1;
                    end else if (spi_rx_strobe) begin
                        txData_d   = 8'hFF;
                        txStrobe_d = 1'b1;
                        underrun_d = 1'b1;
                        loaded_d   = 1'b1;
                    end
                end
                ID: begin
                    if (spi_rx_strobe) begin
                        txStrobe_d = 1'b1;
                        case (idCnt_q)
                            2'd1:    txData_d = JEDEC_ID[15:8];
                            2'd2:    txData_d = JEDEC_ID[7:0];
                            default: txData_d = 8'hFF;
                        endcase
                        if (idCnt_q != 2'd3) begin
                            idCnt_d = idCnt_q + 2'd1;
                        end
                    end
                end
                STAT: begin
                    if (spi_rx_strobe) begin
                        txData_d   = STATUS;
                        txStrobe_d = 1'b1;
                    end
                end
                IGNORE: begin
                    txData_d = 8'hFF;
                end
                IDLE: begin
                    txData_d = txData_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign spi_tx_data   = txData_q;
    assign spi_tx_strobe = txStrobe_q;
    assign mem_rd_req    = rdReq_q;
    assign mem_addr      = memAddr_q;
    assign busy          = (state_q != IDLE);
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: directed bench for the SPI flash sequencer. A
// behavioural memory answers each read request with 0xA0 + low address byte
// after a configurable latency. Every tx reload and every memory request is
// logged so that each scenario can compare against hand-computed sequences.
module tb_spi_flash_sequencer;

    logic        clk;
    logic        reset;
    logic        spi_cs;
    logic        spi_timeout;
    logic        spi_rx_cmd;
    logic        spi_rx_strobe;
    logic [7:0]  spi_rx_data;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_strobe;
    logic        mem_rd_req;
    logic [23:0] mem_addr;
    logic        mem_rd_valid;
    logic [7:0]  mem_rd_data;
    logic        busy;
    logic        underrun;

    int          total = 0;
    int          bad = 0;
    int          memLatency = 2;
    int          byteGap = 20;
    logic [7:0]  txLog[$];
    logic [23:0] reqLog[$];
    logic [23:0] pendAddr;

    spi_flash_sequencer #(
        .ADDR_WIDTH(24),
        .JEDEC_ID  (24'hEF4018),
        .STATUS    (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_cs       (spi_cs),
        .spi_timeout  (spi_timeout),
        .spi_rx_cmd   (spi_rx_cmd),
        .spi_rx_strobe(spi_rx_strobe),
        .spi_rx_data  (spi_rx_data),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_strobe(spi_tx_strobe),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy),
        .underrun     (underrun)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every tx reload and memory request just after the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (spi_tx_strobe === 1'b1) txLog.push_back(spi_tx_data);
            if (mem_rd_req === 1'b1) reqLog.push_back(mem_addr);
        end
    end

    // Memory backend: one request at a time, data = 0xA0 + address low byte.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd_req === 1'b1) begin
                pendAddr = mem_addr;
                repeat (memLatency) @(posedge clk);
                #2;
                mem_rd_valid = 1'b1;
                mem_rd_data  = 8'hA0 + pendAddr[7:0];
                @(posedge clk);
                #2;
                mem_rd_valid = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b, input logic isCmd);
        @(negedge clk);
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        spi_rx_cmd    = isCmd;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
        spi_rx_cmd    = 1'b0;
        repeat (byteGap) @(negedge clk);
    endtask

    task automatic csSelect();
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        txLog.delete();
        reqLog.delete();
    endtask

    task automatic csDeselect();
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset         = 1'b1;
        spi_cs        = 1'b1;
        spi_timeout   = 1'b0;
        spi_rx_cmd    = 1'b0;
        spi_rx_strobe = 1'b0;
        spi_rx_data   = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (spi_tx_data !== 8'hFF) begin bad++; $display("[TB] FAIL reset_tx_data got=%h want=ff", spi_tx_data); end
        total++; if (spi_tx_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_strobe got=%b want=0", spi_tx_strobe); end
        total++; if (mem_rd_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_req got=%b want=0", mem_rd_req); end
        total++; if (mem_addr !== 24'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h want=000000", mem_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_underrun got=%b want=0", underrun); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0]  expTx[3]  = '{8'hA0, 8'hA1, 8'hA2};
        logic [23:0] expReq[4] = '{24'h000100, 24'h000101, 24'h000102, 24'h000103};
        memLatency = 2;
        csSelect();
        sendByte(8'h03, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL read_busy got=%b want=1", busy); end
        sendByte(8'h00, 1'b0);
        sendByte(8'h01, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        total++; if (txLog.size() != 3) begin bad++; $display("[TB] FAIL read_tx_count got=%0d want=3", txLog.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (txLog[i] !== expTx[i]) begin bad++; $display("[TB] FAIL read_tx%0d got=%h want=%h", i, txLog[i], expTx[i]); end
        end
        total++; if (reqLog.size() != 4) begin bad++; $display("[TB] FAIL read_req_count got=%0d want=4", reqLog.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (reqLog[i] !== expReq[i]) begin bad++; $display("[TB] FAIL read_req%0d got=%h want=%h", i, reqLog[i], expReq[i]); end
        end
        total++; if (underrun !== 1'b0) begin bad++; $display("[TB] FAIL read_underrun got=%b want=0", underrun); end
        csDeselect();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL read_end_busy got=%b want=0", busy); end
        total++; if (mem_addr !== 24'h000103) begin bad++; $display("[TB] FAIL read_end_addr got=%h want=000103", mem_addr); end
    endtask

    task automatic test_jedec();
        logic [7:0] expTx[5] = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
        csSelect();
        sendByte(8'h9F, 1'b1);
        for (int i = 0; i < 4; i++) sendByte(8'h00, 1'b0);
        total++; if (txLog.size() != 5) begin bad++; $display("[TB] FAIL jedec_tx_count got=%0d want=5", txLog.size()); end
        for (int i = 0; i < 5; i++) begin
            total++; if (txLog[i] !== expTx[i]) begin bad++; $display("[TB] FAIL jedec_tx%0d got=%h want=%h", i, txLog[i], expTx[i]); end
        end
        total++; if (reqLog.size() != 0) begin bad++; $display("[TB] FAIL jedec_req_count got=%0d want=0", reqLog.size()); end
        csDeselect();
    endtask

    task automatic test_wrap();
        logic [7:0]  expTx[2]  = '{8'h9F, 8'hA0};
        logic [23:0] expReq[3] = '{24'hFFFFFF, 24'h000000, 24'h000001};
        memLatency = 2;
        csSelect();
        sendByte(8'h03, 1'b1);
        sendByte(8'hFF, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'h00, 1'b0);
        total++; if (reqLog.size() != 3) begin bad++; $display("[TB] FAIL wrap_req_count got=%0d want=3", reqLog.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (reqLog[i] !== expReq[i]) begin bad++; $display("[TB] FAIL wrap_req%0d got=%h want=%h", i, reqLog[i], expReq[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (txLog[i] !== expTx[i]) begin bad++; $display("[TB] FAIL wrap_tx%0d got=%h want=%h", i, txLog[i], expTx[i]); end
        end
        csDeselect();
    endtask

    task automatic test_abort();
        csSelect();
        sendByte(8'h03, 1'b1);
        sendByte(8'h12, 1'b0);
        csDeselect();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
        total++; if (spi_tx_data !== 8'hFF) begin bad++; $display("[TB] FAIL abort_tx_data got=%h want=ff", spi_tx_data); end
        total++; if (reqLog.size() != 0) begin bad++; $display("[TB] FAIL abort_req_count got=%0d want=0", reqLog.size()); end
        csSelect();
        sendByte(8'h05, 1'b1);
        sendByte(8'h00, 1'b0);
        total++; if (txLog.size() != 2) begin bad++; $display("[TB] FAIL status_tx_count got=%0d want=2", txLog.size()); end
        for (int i = 0; i < 2; i++) begin
            total++; if (txLog[i] !== 8'h00) begin bad++; $display("[TB] FAIL status_tx%0d got=%h want=00", i, txLog[i]); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL status_busy got=%b want=1", busy); end
        txLog.delete();
        sendByte(8'h9F, 1'b1);
        @(negedge clk);
        spi_timeout = 1'b1;
        @(negedge clk);
        spi_timeout = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_busy got=%b want=0", busy); end
        total++; if (spi_tx_data !== 8'hFF) begin bad++; $display("[TB] FAIL timeout_tx_data got=%h want=ff", spi_tx_data); end
        repeat (2) @(negedge clk);
        total++; if (txLog.size() != 1) begin bad++; $display("[TB] FAIL timeout_tx_count got=%0d want=1", txLog.size()); end
        csDeselect();
    endtask

    task automatic test_fast_read();
        memLatency = 2;
        csSelect();
        sendByte(8'h0B, 1'b1);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h10, 1'b0);
        sendByte(8'h55, 1'b0);
`ifdef SPI_FLASH_FAST_READ_EN
        total++; if (txLog.size() != 2) begin bad++; $display("[TB] FAIL fast_tx_count got=%0d want=2", txLog.size()); end
        total++; if (txLog[0] !== 8'hFF) begin bad++; $display("[TB] FAIL fast_dummy_tx got=%h want=ff", txLog[0]); end
        total++; if (txLog[1] !== 8'hB0) begin bad++; $display("[TB] FAIL fast_data_tx got=%h want=b0", txLog[1]); end
        total++; if (reqLog.size() != 2) begin bad++; $display("[TB] FAIL fast_req_count got=%0d want=2", reqLog.size()); end
        total++; if (reqLog[0] !== 24'h000010) begin bad++; $display("[TB] FAIL fast_req0 got=%h want=000010", reqLog[0]); end
        total++; if (reqLog[1] !== 24'h000011) begin bad++; $display("[TB] FAIL fast_req1 got=%h want=000011", reqLog[1]); end
`else
        total++; if (txLog.size() != 0) begin bad++; $display("[TB] FAIL fast_off_tx_count got=%0d want=0", txLog.size()); end
        total++; if (reqLog.size() != 0) begin bad++; $display("[TB] FAIL fast_off_req_count got=%0d want=0", reqLog.size()); end
        total++; if (spi_tx_data !== 8'hFF) begin bad++; $display("[TB] FAIL fast_off_tx_data got=%h want=ff", spi_tx_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL fast_off_busy got=%b want=1", busy); end
`endif
        csDeselect();
    endtask

    task automatic test_underrun();
        memLatency = 30;
        csSelect();
        sendByte(8'h03, 1'b1);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h20, 1'b0);
        sendByte(8'h00, 1'b0);
        total++; if (underrun !== 1'b1) begin bad++; $display("[TB] FAIL underrun_flag got=%b want=1", underrun); end
        sendByte(8'h00, 1'b0);
        total++; if (txLog.size() != 2) begin bad++; $display("[TB] FAIL underrun_tx_count got=%0d want=2", txLog.size()); end
        total++; if (txLog[0] !== 8'hFF) begin bad++; $display("[TB] FAIL underrun_tx0 got=%h want=ff", txLog[0]); end
        total++; if (txLog[1] !== 8'hC0) begin bad++; $display("[TB] FAIL underrun_tx1 got=%h want=c0", txLog[1]); end
        total++; if (reqLog.size() != 2) begin bad++; $display("[TB] FAIL underrun_req_count got=%0d want=2", reqLog.size()); end
        total++; if (reqLog[1] !== 24'h000021) begin bad++; $display("[TB] FAIL underrun_req1 got=%h want=000021", reqLog[1]); end
        csDeselect();
        total++; if (underrun !== 1'b1) begin bad++; $display("[TB] FAIL underrun_sticky got=%b want=1", underrun); end
        repeat (40) @(negedge clk);
        memLatency = 2;
    endtask

    initial begin
        reset         = 1'b1;
        spi_cs        = 1'b1;
        spi_timeout   = 1'b0;
        spi_rx_cmd    = 1'b0;
        spi_rx_strobe = 1'b0;
        spi_rx_data   = 8'h00;
        test_reset();
        test_read();
        test_jedec();
        test_wrap();
        test_abort();
        test_fast_read();
        test_underrun();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
